jop_dbg_cmd: RTL and testbench

Host-side debug command controller sitting directly upstream of the JOP debug unit. Consumes a byte stream from the debug UART receiver, decodes stall/run/read/write commands, and drives the debug unit's external interface (`dbg_stall`, `dbg_stb`/`dbg_we`/`dbg_adr`/`dbg_dat`, `dbg_ack`). Returns status and read data as a byte stream to the UART transmitter.

---
 rtl/jop_dbg_pkg.sv | 24 ++
 rtl/jop_dbg_cmd.sv | 220 ++++++++++++++++++++++
 tb/tb_jop_dbg_cmd.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jop_dbg_pkg.sv
// Shared definitions for the JOP host-side debug command controller.
//   - opcode bytes received from the debug UART
//   - status bytes returned to the debug UART
//   - controller state encoding
package jop_dbg_pkg;

    localparam logic [7:0] DBG_OP_STALL = 8'h01;
    localparam logic [7:0] DBG_OP_RUN   = 8'h02;
    localparam logic [7:0] DBG_OP_WRITE = 8'h03;
    localparam logic [7:0] DBG_OP_READ  = 8'h04;

    localparam logic [7:0] DBG_RSP_OK   = 8'hA5;
    localparam logic [7:0] DBG_RSP_ERR  = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4,
        ST_SEND = 3'd5
    } dbg_state_e;

endpackage

// File: rtl/jop_dbg_cmd.sv
// Host-side debug command controller for the JOP debug unit.
// Decodes a UART byte stream (STALL / RUN / WRITE / READ), performs one
// strobe/ack transfer on the debug bus per WRITE or READ, and returns a
// status byte (plus read data, MSB first) on the UART transmit stream.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready   command bytes in (valid/ready)
//   tx_data/tx_valid/tx_ready   response bytes out (valid/ready)
//   dbg_stall_o              CPU stall request
//   dbg_stb_o/dbg_we_o       transfer strobe and write enable
//   dbg_adr_o/dbg_dat_o      transfer address and write data
//   dbg_dat_i/dbg_ack_i      read data and transfer acknowledge
module jop_dbg_cmd
    import jop_dbg_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          dbg_stall_o,
    output logic          dbg_stb_o,
    output logic          dbg_we_o,
    output logic [AW-1:0] dbg_adr_o,
    output logic [DW-1:0] dbg_dat_o,
    input  logic [DW-1:0] dbg_dat_i,
    input  logic          dbg_ack_i
);

    localparam int AB = AW / 8;
    localparam int DB = DW / 8;
    localparam int MB = (AB > DB) ? AB : DB;
    localparam int CW = $clog2(MB + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CW-1:0] ADR_LAST = CW'(AB - 1);
    localparam logic [CW-1:0] DAT_LAST = CW'(DB - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    dbg_state_e    state_r;
    logic          is_wr_r;     // current command is WRITE (else READ)
    logic          read_ok_r;   // status byte is followed by read data
    logic [CW-1:0] cnt_r;       // parameter / response byte counter
    logic [TW-1:0] tmo_r;       // strobe cycles elapsed without ack
    logic [AW-1:0] adr_r;
    logic [DW-1:0] wdat_r;
    logic [DW-1:0] rdat_r;      // captured read data, shifted out MSB first
    logic          stall_r;
    logic          stb_r;
    logic          we_r;
    logic [7:0]    tx_data_r;
    logic          tx_valid_r;
    logic          rx_ready_r;
    logic          rx_fire_s;
    logic          tx_fire_s;

    assign rx_fire_s = rx_valid && rx_ready_r;
    assign tx_fire_s = tx_valid_r && tx_ready;

    // rx_ready is held low while reset is applied even though the
    // registered value already reflects the IDLE state.
    assign rx_ready    = rx_ready_r && !rst;
    assign tx_data     = tx_data_r;
    assign tx_valid    = tx_valid_r;
    assign dbg_stall_o = stall_r;
    assign dbg_stb_o   = stb_r;
    assign dbg_we_o    = we_r;
    assign dbg_adr_o   = adr_r;
    assign dbg_dat_o   = wdat_r;

    // Command FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            is_wr_r    <= 1'b0;
            read_ok_r  <= 1'b0;
            cnt_r      <= '0;
            tmo_r      <= '0;
            adr_r      <= '0;
            wdat_r     <= '0;
            rdat_r     <= '0;
            stall_r    <= 1'b0;
            stb_r      <= 1'b0;
            we_r       <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            rx_ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_fire_s) begin
                        case (rx_data)
                            DBG_OP_STALL, DBG_OP_RUN: begin
                                stall_r    <= (rx_data == DBG_OP_STALL);
                                read_ok_r  <= 1'b0;
                                tx_data_r  <= DBG_RSP_OK;
                                tx_valid_r <= 1'b1;
                                rx_ready_r <= 1'b0;
                                state_r    <= ST_RESP;
                            end
                            DBG_OP_WRITE, DBG_OP_READ: begin
                                is_wr_r <= (rx_data == DBG_OP_WRITE);
                                cnt_r   <= '0;
                                state_r <= ST_ADDR;
                            end
                            default: begin
                                // Unknown opcode: only this byte is dropped.
                                read_ok_r  <= 1'b0;
                                tx_data_r  <= DBG_RSP_ERR;
                                tx_valid_r <= 1'b1;
                                rx_ready_r <= 1'b0;
                                state_r    <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (rx_fire_s) begin
                        adr_r <= (adr_r << 8) | AW'(rx_data);
                        if (cnt_r == ADR_LAST) begin
                            cnt_r <= '0;
                            if (is_wr_r) begin
                                state_r <= ST_DATA;
                            end else begin
                                stb_r      <= 1'b1;
                                we_r       <= 1'b0;
                                tmo_r      <= '0;
                                rx_ready_r <= 1'b0;
                                state_r    <= ST_BUS;
                            end
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_fire_s) begin
                        wdat_r <= (wdat_r << 8) | DW'(rx_data);
                        if (cnt_r == DAT_LAST) begin
                            cnt_r      <= '0;
                            stb_r      <= 1'b1;
                            we_r       <= 1'b1;
                            tmo_r      <= '0;
                            rx_ready_r <= 1'b0;
                            state_r    <= ST_BUS;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                end
                ST_BUS: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (dbg_ack_i) begin
                        if (!is_wr_r) begin
                            rdat_r <= dbg_dat_i;
                        end
                        read_ok_r  <= !is_wr_r;
                        stb_r      <= 1'b0;
                        we_r       <= 1'b0;
                        tx_data_r  <= DBG_RSP_OK;
                        tx_valid_r <= 1'b1;
                        state_r    <= ST_RESP;
                    end else if (tmo_r == TMO_LAST) begin
                        read_ok_r  <= 1'b0;
                        stb_r      <= 1'b0;
                        we_r       <= 1'b0;
                        tx_data_r  <= DBG_RSP_ERR;
                        tx_valid_r <= 1'b1;
                        state_r    <= ST_RESP;
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (tx_fire_s) begin
                        if (read_ok_r) begin
                            tx_data_r <= rdat_r[DW-1 -: 8];
                            rdat_r    <= rdat_r << 8;
                            cnt_r     <= '0;
                            state_r   <= ST_SEND;
                        end else begin
                            tx_valid_r <= 1'b0;
                            rx_ready_r <= 1'b1;
                            state_r    <= ST_IDLE;
                        end
                    end
                end
                ST_SEND: begin
                    if (tx_fire_s) begin
                        if (cnt_r == DAT_LAST) begin
                            tx_valid_r <= 1'b0;
                            rx_ready_r <= 1'b1;
                            state_r    <= ST_IDLE;
                        end else begin
                            tx_data_r <= rdat_r[DW-1 -: 8];
                            rdat_r    <= rdat_r << 8;
                            cnt_r     <= cnt_r + CW'(1);
                        end
                    end
                end
                default: begin
                    stb_r      <= 1'b0;
                    we_r       <= 1'b0;
                    tx_valid_r <= 1'b0;
                    rx_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jop_dbg_cmd.sv
// Self-checking bench for jop_dbg_cmd (AW=DW=32, ACK_TIMEOUT=4).
// Expected response bytes are queued when a command is issued and
// compared as the DUT hands them out on the tx stream.
module tb_jop_dbg_cmd;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        dbg_stall_o;
    logic        dbg_stb_o;
    logic        dbg_we_o;
    logic [31:0] dbg_adr_o;
    logic [31:0] dbg_dat_o;
    logic [31:0] dbg_dat_i;
    logic        dbg_ack_i;

    int total_cnt;
    int pass_cnt;
    logic [7:0] exp_q[$];

    jop_dbg_cmd #(.AW(32), .DW(32), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .dbg_stall_o(dbg_stall_o), .dbg_stb_o(dbg_stb_o), .dbg_we_o(dbg_we_o),
        .dbg_adr_o(dbg_adr_o), .dbg_dat_o(dbg_dat_o),
        .dbg_dat_i(dbg_dat_i), .dbg_ack_i(dbg_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            tick();
            n++;
        end
        if (!rx_ready) begin
            total_cnt++;
            $display("FAIL rx_accept: rx_ready=%0b required 1 for byte %02h", rx_ready, b);
        end
        tick();
        rx_valid = 1'b0;
    endtask

    // Wait for the next response byte, compare it with the scoreboard
    // head and complete the handshake.
    task automatic expect_tx(input string name);
        int n;
        logic [7:0] exp_b;
        n = 0;
        while (!tx_valid && n < 50) begin
            tick();
            n++;
        end
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        total_cnt++;
        if (!tx_valid) begin
            $display("FAIL %s: no tx byte within budget, required %02h", name, exp_b);
        end else if (tx_data !== exp_b) begin
            $display("FAIL %s: tx_data=%02h required %02h", name, tx_data, exp_b);
        end else begin
            pass_cnt++;
        end
        if (tx_valid) begin
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        total_cnt++;
        if ({rx_ready, tx_valid, dbg_stall_o, dbg_stb_o, dbg_we_o} !== 5'b00000 ||
            dbg_adr_o !== 32'h0 || dbg_dat_o !== 32'h0 || tx_data !== 8'h00) begin
            $display("FAIL reset_outputs: rdy=%0b txv=%0b stall=%0b stb=%0b we=%0b adr=%h dat=%h txd=%h required all 0",
                     rx_ready, tx_valid, dbg_stall_o, dbg_stb_o, dbg_we_o, dbg_adr_o, dbg_dat_o, tx_data);
        end else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if (rx_ready !== 1'b1) $display("FAIL reset_release: rx_ready=%0b required 1", rx_ready);
        else pass_cnt++;
    endtask

    task automatic test_stall_run();
        send_byte(8'h01);
        exp_q.push_back(8'hA5);
        total_cnt++;
        if (dbg_stall_o !== 1'b1 || tx_valid !== 1'b1)
            $display("FAIL stall_set: stall=%0b txv=%0b required 1 1", dbg_stall_o, tx_valid);
        else pass_cnt++;
        expect_tx("stall_rsp");
        send_byte(8'h02);
        exp_q.push_back(8'hA5);
        total_cnt++;
        if (dbg_stall_o !== 1'b0 || tx_valid !== 1'b1)
            $display("FAIL run_clear: stall=%0b txv=%0b required 0 1", dbg_stall_o, tx_valid);
        else pass_cnt++;
        expect_tx("run_rsp");
    endtask

    task automatic test_write();
        logic [7:0] bytes [9];
        bytes = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 9; i++) send_byte(bytes[i]);
        total_cnt++;
        if (dbg_stb_o !== 1'b1 || dbg_we_o !== 1'b1 || dbg_adr_o !== 32'h00000010 ||
            dbg_dat_o !== 32'hDEADBEEF || rx_ready !== 1'b0)
            $display("FAIL write_bus: stb=%0b we=%0b adr=%h dat=%h rdy=%0b required 1 1 00000010 deadbeef 0",
                     dbg_stb_o, dbg_we_o, dbg_adr_o, dbg_dat_o, rx_ready);
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++;
            if (dbg_stb_o !== 1'b1 || tx_valid !== 1'b0)
                $display("FAIL write_hold: cycle %0d stb=%0b txv=%0b required 1 0", c + 2, dbg_stb_o, tx_valid);
            else pass_cnt++;
        end
        dbg_ack_i = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        dbg_ack_i = 1'b0;
        total_cnt++;
        if (dbg_stb_o !== 1'b0 || dbg_we_o !== 1'b0 || tx_valid !== 1'b1)
            $display("FAIL write_ack: stb=%0b we=%0b txv=%0b required 0 0 1", dbg_stb_o, dbg_we_o, tx_valid);
        else pass_cnt++;
        expect_tx("write_rsp");
    endtask

    task automatic test_read();
        logic [7:0] bytes [5];
        logic [7:0] held;
        bytes = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h20};
        send_byte(8'h01);
        exp_q.push_back(8'hA5);
        expect_tx("read_pre_stall");
        for (int i = 0; i < 5; i++) send_byte(bytes[i]);
        total_cnt++;
        if (dbg_stb_o !== 1'b1 || dbg_we_o !== 1'b0 || dbg_adr_o !== 32'h00000020)
            $display("FAIL read_bus: stb=%0b we=%0b adr=%h required 1 0 00000020", dbg_stb_o, dbg_we_o, dbg_adr_o);
        else pass_cnt++;
        dbg_dat_i = 32'h12345678;
        dbg_ack_i = 1'b1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h56);
        exp_q.push_back(8'h78);
        tick();
        dbg_ack_i = 1'b0;
        dbg_dat_i = 32'h0;
        total_cnt++;
        if (dbg_stb_o !== 1'b0 || dbg_stall_o !== 1'b1)
            $display("FAIL read_ack: stb=%0b stall=%0b required 0 1", dbg_stb_o, dbg_stall_o);
        else pass_cnt++;
        expect_tx("read_status");
        expect_tx("read_b0");
        held = exp_q[0];
        for (int c = 0; c < 5; c++) begin
            tick();
            total_cnt++;
            if (tx_valid !== 1'b1 || tx_data !== held)
                $display("FAIL read_hold: cycle %0d txv=%0b txd=%02h required 1 %02h", c, tx_valid, tx_data, held);
            else pass_cnt++;
        end
        expect_tx("read_b1");
        expect_tx("read_b2");
        expect_tx("read_b3");
        total_cnt++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1)
            $display("FAIL read_done: txv=%0b rdy=%0b required 0 1", tx_valid, rx_ready);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic [7:0] bytes [5];
        int hi;
        bytes = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h30};
        for (int i = 0; i < 5; i++) send_byte(bytes[i]);
        hi = 0;
        while (dbg_stb_o && hi < 20) begin
            hi++;
            tick();
        end
        exp_q.push_back(8'hEE);
        total_cnt++;
        if (hi != 4) $display("FAIL timeout_len: strobe cycles=%0d required 4", hi);
        else pass_cnt++;
        total_cnt++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hEE)
            $display("FAIL timeout_rsp_now: txv=%0b txd=%02h required 1 ee", tx_valid, tx_data);
        else pass_cnt++;
        dbg_ack_i = 1'b1;
        tick();
        dbg_ack_i = 1'b0;
        total_cnt++;
        if (dbg_stb_o !== 1'b0 || tx_data !== 8'hEE)
            $display("FAIL late_ack: stb=%0b txd=%02h required 0 ee", dbg_stb_o, tx_data);
        else pass_cnt++;
        expect_tx("timeout_rsp");
        dbg_ack_i = 1'b1;
        tick();
        dbg_ack_i = 1'b0;
        total_cnt++;
        if (dbg_stb_o !== 1'b0 || tx_valid !== 1'b0)
            $display("FAIL idle_ack: stb=%0b txv=%0b required 0 0", dbg_stb_o, tx_valid);
        else pass_cnt++;
    endtask

    task automatic test_bad_opcode();
        send_byte(8'h02);
        exp_q.push_back(8'hA5);
        expect_tx("bad_pre_run");
        send_byte(8'h7F);
        exp_q.push_back(8'hEE);
        total_cnt++;
        if (dbg_stall_o !== 1'b0 || tx_valid !== 1'b1)
            $display("FAIL bad_op: stall=%0b txv=%0b required 0 1", dbg_stall_o, tx_valid);
        else pass_cnt++;
        expect_tx("bad_rsp");
        send_byte(8'h01);
        exp_q.push_back(8'hA5);
        total_cnt++;
        if (dbg_stall_o !== 1'b1) $display("FAIL after_bad: stall=%0b required 1", dbg_stall_o);
        else pass_cnt++;
        expect_tx("after_bad_rsp");
    endtask

    task automatic test_reset_in_bus();
        logic [7:0] bytes [9];
        bytes = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 9; i++) send_byte(bytes[i]);
        total_cnt++;
        if (dbg_stb_o !== 1'b1 || dbg_stall_o !== 1'b1)
            $display("FAIL rbus_pre: stb=%0b stall=%0b required 1 1", dbg_stb_o, dbg_stall_o);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++;
        if (dbg_stb_o !== 1'b0 || dbg_stall_o !== 1'b0 || rx_ready !== 1'b0 || tx_valid !== 1'b0)
            $display("FAIL rbus_reset: stb=%0b stall=%0b rdy=%0b txv=%0b required 0 0 0 0",
                     dbg_stb_o, dbg_stall_o, rx_ready, tx_valid);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if (rx_ready !== 1'b1 || dbg_stb_o !== 1'b0)
            $display("FAIL rbus_release: rdy=%0b stb=%0b required 1 0", rx_ready, dbg_stb_o);
        else pass_cnt++;
        send_byte(8'h01);
        exp_q.push_back(8'hA5);
        expect_tx("rbus_followup");
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
        dbg_dat_i = 32'h0;
        dbg_ack_i = 1'b0;
        test_reset();
        test_stall_run();
        test_write();
        test_read();
        test_timeout();
        test_bad_opcode();
        test_reset_in_bus();
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_empty: %0d bytes left required 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
